dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Responder end of the core's data-memory interface: accepts one load/store request at a time from the
//   MEM stage over a valid/ready handshake and returns a response after a fixed number of wait states.
//   Performs byte/half/word lane merge on stores and lane extract plus sign/zero extension on loads.
//   Replaces the single-cycle data RAM when the core is built for multi-cycle memory.
// PARAMETERS
//   DEPTH_WORDS  1024  number of 32-bit words; word index = req_addr[$clog2(DEPTH_WORDS)+1:2], upper bits ignored (wrap)
//   WAIT_STATES  2     cycles spent in WAIT between accept and response (0 legal)
// PORTS
//   clk             in   1   clock, rising edge
//   reset           in   1   asynchronous, active-high reset
//   req_valid       in   1   request present
//   req_ready       out  1   responder can accept (high only in IDLE)
//   req_addr        in   32  byte address
//   req_wdata       in   32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
//   req_write_ctrl  in   2   00 none, 01 SB, 10 SH, 11 SW
//   req_read_ctrl   in   3   000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 110/111 treated as none
//   rsp_valid       out  1   response present
//   rsp_ready       in   1   initiator accepts response
//   rsp_rdata       out  32  extended load data; 0 for stores and no-ops
//   rsp_err         out  1   misalignment error (only with DMEM_MISALIGN_TRAP_EN; else tied 0)
// BEHAVIOUR
//   - Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; memory array not cleared.
//   - FSM: IDLE --(req_valid&&req_ready)--> WAIT (or RESP if WAIT_STATES==0);
//     WAIT --(counter==WAIT_STATES-1)--> RESP; RESP --(rsp_ready)--> IDLE.
//   - Accept latches addr/wdata/ctrl; counter cleared on accept, increments each WAIT cycle.
//   - rsp_valid rises exactly WAIT_STATES+1 cycles after the accept edge; rsp_rdata/rsp_err stable
//     while rsp_valid && !rsp_ready. No new request accepted in the cycle the response retires
//     (req_ready returns the cycle after the RESP->IDLE edge): max throughput 1 per WAIT_STATES+2 cycles.
//   - Store commits to the array on the edge entering RESP; byte enables: SB -> lane addr[1:0],
//     SH -> lanes {addr[1],0}+{0,1}, SW -> all four lanes. Unselected lanes unchanged.
//   - Load reads the array on the edge entering RESP; LB/LH sign-extend, LBU/LHU zero-extend, LW raw.
//   - write_ctrl!=0 and read_ctrl!=0 together: store performed, load ignored, rsp_rdata=0.
//   - Both ctrl none: accepted and completes as a normal transaction, no array change, rsp_rdata=0.
//   - Store then load to same word in consecutive transactions returns the stored data (no bypass needed: serialised).
//   - Reset asserted mid-transaction: aborts to IDLE; a store not yet at the RESP edge is never committed.
//   - Inputs other than req_valid are don't-care when not accepted.
// CONFIGURATION
//   DMEM_MISALIGN_TRAP_EN defined: SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]!=0, are misaligned:
//     no array write, rsp_rdata=0, rsp_err=1 for that response; latency unchanged.
//   Undefined: misalignment ignored -- halfword uses addr[1] only, word ignores addr[1:0]; rsp_err=0 always.
// STRUCTURE
//   - dmem_pkg: enums for write_ctrl (WR_NONE/WR_B/WR_H/WR_W) and read_ctrl (RD_NONE/RD_B/RD_H/RD_W/RD_BU/RD_HU),
//     state typedef (S_IDLE/S_WAIT/S_RESP), shared with control_unit encodings.
//   - Sub-module dmem_lane_align: combinational byte-enable/write-data shift for stores and
//     lane extract + extension for loads, plus misaligned flag. FSM, counter and array stay in dmem_responder.
// TESTING
//   1. SW addr 0x10 data 0xDEADBEEF, then LW 0x10, WAIT_STATES=2 -> rsp_valid 3 cycles after each accept, rdata 0xDEADBEEF.
//   2. Word 0x20 = 0x00000000; SB 0x23 data 0x80 -> word 0x80000000; LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080.
//   3. SH 0x32 data 0x8001 over 0x11111111 -> word 0x80011111; LH 0x32 -> 0xFFFF8001; LHU -> 0x00008001.
//   4. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0, second req_valid not accepted.
//   5. Assert reset during WAIT of SW 0x40 data 0x12345678 -> outputs at reset values, LW 0x40 returns prior value.
//   6. DMEM_MISALIGN_TRAP_EN: SW addr 0x41 -> rsp_err=1, rdata 0, word 0x40 unchanged; undefined: writes word 0x40.

Source files
------------

// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared encodings for the data-memory interface (ctrl fields, FSM).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

  typedef enum logic [1:0] {
    WR_NONE = 2'b00,
    WR_B    = 2'b01,
    WR_H    = 2'b10,
    WR_W    = 2'b11
  } wr_ctrl_e;

  // 3'b110 and 3'b111 are intentionally absent and behave as RD_NONE
  typedef enum logic [2:0] {
    RD_NONE = 3'b000,
    RD_B    = 3'b001,
    RD_H    = 3'b010,
    RD_W    = 3'b011,
    RD_BU   = 3'b100,
    RD_HU   = 3'b101
  } rd_ctrl_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
// Module   : dmem_lane_align
// Purpose  : Store byte-enable/lane replication and load lane extract with
//            sign/zero extension. Misalignment trapping when the macro
//            DMEM_MISALIGN_TRAP_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [1:0]  write_ctrl,
  input  logic [2:0]  read_ctrl,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic        store_mis;
  logic        load_mis;

  assign rbyte = rword[{addr_lo, 3'b000} +: 8];
  assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    store_mis = 1'b0;
    load_mis  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    store_mis = ((write_ctrl == WR_H) && addr_lo[0]) ||
                ((write_ctrl == WR_W) && (addr_lo != 2'b00));
    load_mis  = (((read_ctrl == RD_H) || (read_ctrl == RD_HU)) && addr_lo[0]) ||
                ((read_ctrl == RD_W) && (addr_lo != 2'b00));
`endif
    // A store takes precedence, so only its alignment matters when present
    misaligned = (write_ctrl != WR_NONE) ? store_mis : load_mis;
  end

  // Store data is replicated into every lane; byte_en picks the real target
  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = 32'h0;
    case (write_ctrl)
      WR_B: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      WR_H: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      WR_W: begin
        byte_en    = 4'b1111;
        wdata_lane = wdata;
      end
      default: ;
    endcase
    if (misaligned) byte_en = 4'b0000;
  end

  always_comb begin
    rdata_ext = 32'h0;
    case (read_ctrl)
      RD_B:    rdata_ext = {{24{rbyte[7]}}, rbyte};
      RD_H:    rdata_ext = {{16{rhalf[15]}}, rhalf};
      RD_W:    rdata_ext = rword;
      RD_BU:   rdata_ext = {24'h0, rbyte};
      RD_HU:   rdata_ext = {16'h0, rhalf};
      default: rdata_ext = 32'h0;
    endcase
    if ((write_ctrl != WR_NONE) || misaligned) rdata_ext = 32'h0;
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Purpose  : Multi-cycle data-memory responder: valid/ready request, fixed
//            wait states, lane-merged stores and extended loads.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_write_ctrl,
  input  logic [2:0]  req_read_ctrl,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int AW    = IDX_W + 2;
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = (WAIT_STATES > 1) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [1:0]         wctl_q, wctl_d;
  logic [2:0]         rctl_q, rctl_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               enter_resp;

  logic [31:0]        mem_q [DEPTH_WORDS];

  // In IDLE the live request feeds the datapath so WAIT_STATES==0 works
  logic               idle;
  logic [AW-1:0]      cur_addr;
  logic [31:0]        cur_wdata;
  logic [1:0]         cur_wctl;
  logic [2:0]         cur_rctl;
  logic [IDX_W-1:0]   widx;
  logic [31:0]        rword;
  logic [3:0]         byte_en;
  logic [31:0]        wdata_lane;
  logic [31:0]        rdata_ext;
  logic               misaligned;
  logic               mem_we;

  assign idle      = (state_q == S_IDLE);
  assign cur_addr  = idle ? req_addr[AW-1:0] : addr_q;
  assign cur_wdata = idle ? req_wdata        : wdata_q;
  assign cur_wctl  = idle ? req_write_ctrl   : wctl_q;
  assign cur_rctl  = idle ? req_read_ctrl    : rctl_q;
  assign widx      = cur_addr[AW-1:2];
  assign rword     = mem_q[widx];

  generate
    if (AW < 32) begin : g_unused_addr
      logic unused_addr_bits;
      assign unused_addr_bits = ^req_addr[31:AW];
    end
  endgenerate

  dmem_lane_align u_align (
    .addr_lo    (cur_addr[1:0]),
    .wdata      (cur_wdata),
    .write_ctrl (cur_wctl),
    .read_ctrl  (cur_rctl),
    .rword      (rword),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .misaligned (misaligned)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wctl_d     = wctl_q;
    rctl_d     = rctl_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr[AW-1:0];
          wdata_d = req_wdata;
          wctl_d  = req_write_ctrl;
          rctl_d  = req_read_ctrl;
          cnt_d   = '0;
          if (WAIT_STATES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      rdata_d = rdata_ext;
      err_d   = misaligned;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      wctl_q  <= 2'b00;
      rctl_q  <= 3'b000;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wctl_q  <= wctl_d;
      rctl_q  <= rctl_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset; the reset gate keeps an aborted store from landing
  assign mem_we = enter_resp && !reset;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && byte_en[i]) mem_q[widx][8*i +: 8] <= wdata_lane[8*i +: 8];
    end
  end

  assign req_ready = idle;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed scoreboard bench for dmem_responder (WAIT_STATES=2).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_responder;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [1:0]  req_write_ctrl = 2'b00;
  logic [2:0]  req_read_ctrl = 3'b000;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_write_ctrl (req_write_ctrl),
    .req_read_ctrl  (req_read_ctrl),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [int];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_mis(input logic [31:0] a, input logic [1:0] wc, input logic [2:0] rc);
    logic m;
    m = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (wc != 2'b00) m = (wc == 2'b10 && a[0]) || (wc == 2'b11 && a[1:0] != 2'b00);
    else             m = ((rc == 3'b010 || rc == 3'b101) && a[0]) || (rc == 3'b011 && a[1:0] != 2'b00);
`else
    if (a[0] && wc == 2'b11 && rc == 3'b111) m = 1'b0;
`endif
    return m;
  endfunction

  // Reference model: updates shadow memory for stores and returns the expected response
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] wd,
                                 input logic [1:0] wc, input logic [2:0] rc);
    exp_t        e;
    int          key;
    int          sh;
    logic [31:0] word;
    logic [7:0]  b;
    logic [15:0] h;
    key  = int'(a[11:2]);
    sh   = 8 * int'(a[1:0]);
    word = mdl.exists(key) ? mdl[key] : 32'h0;
    e.err   = is_mis(a, wc, rc);
    e.rdata = 32'h0;
    b = 8'(word >> sh);
    h = a[1] ? word[31:16] : word[15:0];
    if (wc != 2'b00) begin
      if (!e.err) begin
        case (wc)
          2'b01: word[sh +: 8] = wd[7:0];
          2'b10: if (a[1]) word[31:16] = wd[15:0]; else word[15:0] = wd[15:0];
          default: word = wd;
        endcase
        mdl[key] = word;
      end
    end else if (!e.err) begin
      case (rc)
        3'b001: e.rdata = {{24{b[7]}}, b};
        3'b010: e.rdata = {{16{h[15]}}, h};
        3'b011: e.rdata = word;
        3'b100: e.rdata = {24'h0, b};
        3'b101: e.rdata = {16'h0, h};
        default: e.rdata = 32'h0;
      endcase
    end
    return e;
  endfunction

  task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] wc, input logic [2:0] rc, input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid      = 1'b1;
    req_addr       = a;
    req_wdata      = wd;
    req_write_ctrl = wc;
    req_read_ctrl  = rc;
    rsp_ready      = 1'b0;
    sb.push_back(model(a, wd, wc, rc));
    @(negedge clk);
    req_valid      = 1'b0;
    req_addr       = 32'hFFFF_FFFF;
    req_wdata      = 32'hFFFF_FFFF;
    req_write_ctrl = 2'b11;
    req_read_ctrl  = 3'b011;
    n = 1;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_latency"}, 32'(n), 32'(WS + 1));
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard"}, 32'd0, 32'd1);
      e.rdata = 32'h0;
      e.err   = 1'b0;
    end else begin
      e = sb.pop_front();
    end
    chk({tag, "_rdata"}, rsp_rdata, e.rdata);
    chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
    for (int i = 0; i < hold; i++) begin
      req_valid      = 1'b1;
      req_addr       = 32'h10;
      req_wdata      = 32'h0BAD_0BAD;
      req_write_ctrl = 2'b11;
      req_read_ctrl  = 3'b000;
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, rsp_rdata, e.rdata);
      chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_retired"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    txn("sw10", 32'h10, 32'hDEADBEEF, 2'b11, 3'b000, 0);
    txn("lw10", 32'h10, 32'h0, 2'b00, 3'b011, 0);

    txn("sw20", 32'h20, 32'h0000_0000, 2'b11, 3'b000, 0);
    txn("sb23", 32'h23, 32'h0000_0080, 2'b01, 3'b000, 0);
    txn("lw20", 32'h20, 32'h0, 2'b00, 3'b011, 0);
    txn("lb23", 32'h23, 32'h0, 2'b00, 3'b001, 0);
    txn("lbu23", 32'h23, 32'h0, 2'b00, 3'b100, 0);
    txn("sb21", 32'h21, 32'h0000_00FF, 2'b01, 3'b000, 0);
    txn("lw20b", 32'h20, 32'h0, 2'b00, 3'b011, 0);

    txn("sw30", 32'h30, 32'h1111_1111, 2'b11, 3'b000, 0);
    txn("sh32", 32'h32, 32'h0000_8001, 2'b10, 3'b000, 0);
    txn("lw30", 32'h30, 32'h0, 2'b00, 3'b011, 0);
    txn("lh32", 32'h32, 32'h0, 2'b00, 3'b010, 0);
    txn("lhu32", 32'h32, 32'h0, 2'b00, 3'b101, 0);
    txn("lh30", 32'h30, 32'h0, 2'b00, 3'b010, 0);

    txn("lw10_hold", 32'h10, 32'h0, 2'b00, 3'b011, 5);
    txn("lw10_after_hold", 32'h10, 32'h0, 2'b00, 3'b011, 0);

    txn("swlw50", 32'h50, 32'hA5A5_A5A5, 2'b11, 3'b011, 0);
    txn("lw50", 32'h50, 32'h0, 2'b00, 3'b011, 0);
    txn("noop", 32'h10, 32'h0, 2'b00, 3'b000, 0);
    txn("rd110", 32'h10, 32'h0, 2'b00, 3'b110, 0);
    txn("lw_wrap", 32'h1010, 32'h0, 2'b00, 3'b011, 0);

    txn("sw40", 32'h40, 32'hCAFE_F00D, 2'b11, 3'b000, 0);
    req_valid      = 1'b1;
    req_addr       = 32'h40;
    req_wdata      = 32'h1234_5678;
    req_write_ctrl = 2'b11;
    req_read_ctrl  = 3'b000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_busy", 32'(req_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk_reset_vals("abort");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    txn("lw40_after_abort", 32'h40, 32'h0, 2'b00, 3'b011, 0);

    txn("sw41", 32'h41, 32'h55AA_55AA, 2'b11, 3'b000, 0);
    txn("lw40", 32'h40, 32'h0, 2'b00, 3'b011, 0);
    txn("lh31", 32'h31, 32'h0, 2'b00, 3'b010, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
